// File: rtl/sha256_ctrl_if.sv
// Block-in / digest-out handshake and datapath strobes between sha256_ctrl and its padder, scheduler and datapath.
// The controller uses the slave modport; the surrounding environment uses master.
interface sha256_ctrl_if #(
  parameter int unsigned ROUNDS = 64
);
  localparam int unsigned IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  logic             blk_valid;
  logic             blk_last;
  logic             blk_ready;
  logic             sched_load;
  logic             h_init;
  logic             round_en;
  logic [IDX_W-1:0] round_idx;
  logic             h_update;
  logic             digest_valid;
  logic             digest_ready;
  logic             busy;

  modport slave (
    input  blk_valid, blk_last, digest_ready,
    output blk_ready, sched_load, h_init, round_en, round_idx, h_update, digest_valid, busy
  );

  modport master (
    output blk_valid, blk_last, digest_ready,
    input  blk_ready, sched_load, h_init, round_en, round_idx, h_update, digest_valid, busy
  );
endinterface

// File: rtl/sha256_ctrl.sv
// SHA-256 block sequencer: accepts padded blocks, runs ROUNDS compression rounds and hands off the digest.
// Optional feature: define SHA256_CTRL_ABORT_EN to add an abort input that drops any in-flight message.
module sha256_ctrl #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic clk,
  input  logic reset,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic abort,
`endif
  sha256_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             last_q, last_d;

  // State register; first_q marks that the next LOAD starts a fresh message
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.blk_valid) begin
          state_d = S_LOAD;
          last_d  = bus.blk_last;
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
        cnt_d   = '0;
      end
      S_ROUND: begin
        if (cnt_q == LAST_ROUND) begin
          state_d = S_UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_UPDATE: begin
        first_d = 1'b0;
        state_d = last_q ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (bus.digest_ready) begin
          first_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef SHA256_CTRL_ABORT_EN
    // Abort discards the current message; the next block restarts from H0
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      first_d = 1'b1;
    end
`endif
  end

  // Moore outputs decoded from the state registers only
  assign bus.blk_ready    = (state_q == S_IDLE);
  assign bus.sched_load   = (state_q == S_LOAD);
  assign bus.h_init       = (state_q == S_LOAD) && first_q;
  assign bus.round_en     = (state_q == S_ROUND);
  assign bus.round_idx    = cnt_q;
  assign bus.h_update     = (state_q == S_UPDATE);
  assign bus.digest_valid = (state_q == S_DONE);
  assign bus.busy         = (state_q != S_IDLE);

  a_strobe_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0({bus.sched_load, bus.round_en, bus.h_update}));
  a_hinit_with_load : assert property (@(posedge clk) disable iff (reset)
    bus.h_init |-> bus.sched_load);
endmodule

// File: tb/tb_sha256_ctrl.sv
// Self-checking bench for sha256_ctrl: vector table over a single-block trace, scoreboard of
// expected LOAD/UPDATE/digest cycles, and directed sequences for multi-block, stall, reset and abort.
module tb_sha256_ctrl;
  localparam int unsigned ROUNDS = 64;
  localparam int TRACE_N = 1024;

  logic clk = 1'b0;
  logic reset;
`ifdef SHA256_CTRL_ABORT_EN
  logic abort;
`endif

  sha256_ctrl_if #(.ROUNDS(ROUNDS)) bus ();

  sha256_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SHA256_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues filled by the driver at accept time
  int q_load_cyc[$];
  bit q_load_hi[$];
  int q_upd_cyc[$];
  int q_dig_cyc[$];
  bit exp_first;

  typedef struct packed {
    logic       rdy, sl, hi, re, hu, dv, bsy;
    logic [5:0] idx;
  } obs_t;
  obs_t trace [TRACE_N];

  int last_load_cyc = 0;
  bit prev_dv = 1'b0;

  // Monitor on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (cyc < TRACE_N)
        trace[cyc] = '{bus.blk_ready, bus.sched_load, bus.h_init, bus.round_en,
                       bus.h_update, bus.digest_valid, bus.busy, bus.round_idx};
      check("busy_vs_ready", int'(bus.busy), int'(!bus.blk_ready));
      check("strobe_exclusive",
            int'(bus.sched_load) + int'(bus.round_en) + int'(bus.h_update) <= 1 &&
            !(bus.h_init && !bus.sched_load), 1);
      if (bus.sched_load) begin
        last_load_cyc = cyc;
        if (q_load_cyc.size() == 0) check("unexpected_load", 1, 0);
        else begin
          check("load_cycle", cyc, q_load_cyc.pop_front());
          check("h_init", int'(bus.h_init), int'(q_load_hi.pop_front()));
        end
      end
      if (bus.round_en) check("round_idx", int'(bus.round_idx), cyc - last_load_cyc - 1);
      if (bus.h_update) begin
        if (q_upd_cyc.size() == 0) check("unexpected_h_update", 1, 0);
        else check("h_update_cycle", cyc, q_upd_cyc.pop_front());
      end
      if (bus.digest_valid && !prev_dv) begin
        if (q_dig_cyc.size() == 0) check("unexpected_digest", 1, 0);
        else check("digest_cycle", cyc, q_dig_cyc.pop_front());
      end
      prev_dv = bus.digest_valid;
    end else begin
      prev_dv = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    q_load_cyc.delete();
    q_load_hi.delete();
    q_upd_cyc.delete();
    q_dig_cyc.delete();
    exp_first = 1'b1;
  endtask

  // Present a block and wait (bounded) for the accept; returns the accept cycle
  task automatic send_block(input bit last, output int t_acc);
    bus.blk_valid = 1'b1;
    bus.blk_last  = last;
    t_acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.blk_ready) begin
        t_acc = cyc;
        break;
      end
      step();
    end
    if (t_acc < 0) check("accept_timeout", 0, 1);
    else begin
      q_load_cyc.push_back(t_acc + 1);
      q_load_hi.push_back(exp_first);
      q_upd_cyc.push_back(t_acc + 2 + ROUNDS);
      if (last) q_dig_cyc.push_back(t_acc + 3 + ROUNDS);
      exp_first = 1'b0;
    end
    step();
    bus.blk_valid = 1'b0;
    bus.blk_last  = 1'b0;
  endtask

  task automatic take_digest();
    int n;
    n = 0;
    while (!bus.digest_valid && n < 300) begin
      step();
      n++;
    end
    check("digest_wait", int'(bus.digest_valid), 1);
    bus.digest_ready = 1'b1;
    step();
    bus.digest_ready = 1'b0;
    exp_first = 1'b1;
    check("ready_after_handshake", int'(bus.blk_ready), 1);
    check("dv_after_handshake", int'(bus.digest_valid), 0);
  endtask

  task automatic wait_round(input int idx);
    int n;
    n = 0;
    while (!(bus.round_en && int'(bus.round_idx) == idx) && n < 300) begin
      step();
      n++;
    end
    check("wait_round", int'(bus.round_idx), idx);
  endtask

  typedef struct {
    int off;
    bit rdy, sl, hi, re, hu, dv, bsy;
    int idx;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int t0, t1, t2;
    obs_t o;

    vecs[0] = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[2] = '{2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 31};
    vecs[5] = '{65, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 63};
    vecs[6] = '{66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[7] = '{67, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[8] = '{68, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};

    reset = 1'b1;
    bus.blk_valid    = 1'b0;
    bus.blk_last     = 1'b0;
    bus.digest_ready = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    clear_sb();
    step();
    step();
    reset = 1'b0;

    check("rst_blk_ready", int'(bus.blk_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_strobes", int'({bus.sched_load, bus.h_init, bus.round_en, bus.h_update}), 0);
    check("rst_digest_valid", int'(bus.digest_valid), 0);
    check("rst_round_idx", int'(bus.round_idx), 0);

    // Single block, then digest stalled for 10 cycles with blk_valid high
    send_block(1'b1, t0);
    while (cyc < t0 + 69) step();
    for (int i = 0; i < 9; i++) begin
      o = trace[t0 + vecs[i].off];
      check($sformatf("vec%0d.blk_ready", i),    int'(o.rdy), int'(vecs[i].rdy));
      check($sformatf("vec%0d.sched_load", i),   int'(o.sl),  int'(vecs[i].sl));
      check($sformatf("vec%0d.h_init", i),       int'(o.hi),  int'(vecs[i].hi));
      check($sformatf("vec%0d.round_en", i),     int'(o.re),  int'(vecs[i].re));
      check($sformatf("vec%0d.h_update", i),     int'(o.hu),  int'(vecs[i].hu));
      check($sformatf("vec%0d.digest_valid", i), int'(o.dv),  int'(vecs[i].dv));
      check($sformatf("vec%0d.busy", i),         int'(o.bsy), int'(vecs[i].bsy));
      check($sformatf("vec%0d.round_idx", i),    int'(o.idx), vecs[i].idx);
    end
    bus.blk_valid = 1'b1;
    bus.blk_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_digest_valid", int'(bus.digest_valid), 1);
      check("stall_blk_ready", int'(bus.blk_ready), 0);
    end
    bus.blk_valid = 1'b0;
    bus.blk_last  = 1'b0;
    take_digest();

    // Two-block message: second block accepted exactly when the first UPDATE returns to IDLE
    send_block(1'b0, t1);
    send_block(1'b1, t2);
    check("second_accept_gap", t2 - t1, 67);
    take_digest();

    // Synchronous reset mid-round
    send_block(1'b1, t0);
    wait_round(30);
    reset = 1'b1;
    clear_sb();
    step();
    reset = 1'b0;
    check("midrst_blk_ready", int'(bus.blk_ready), 1);
    check("midrst_round_en", int'(bus.round_en), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_round_idx", int'(bus.round_idx), 0);
    send_block(1'b1, t0);
    take_digest();

    // digest_ready outside DONE is ignored
    bus.digest_ready = 1'b1;
    send_block(1'b1, t0);
    bus.digest_ready = 1'b0;
    take_digest();

`ifdef SHA256_CTRL_ABORT_EN
    abort = 1'b1;
    step();
    check("abort_idle_ready", int'(bus.blk_ready), 1);
    abort = 1'b0;
    send_block(1'b1, t0);
    wait_round(10);
    abort = 1'b1;
    clear_sb();
    step();
    abort = 1'b0;
    check("abort_blk_ready", int'(bus.blk_ready), 1);
    check("abort_round_en", int'(bus.round_en), 0);
    for (int i = 0; i < 70; i++) begin
      step();
      check("abort_no_h_update", int'(bus.h_update), 0);
      check("abort_no_digest", int'(bus.digest_valid), 0);
    end
    send_block(1'b1, t0);
    take_digest();
`else
    $display("note: abort input not present in this build");
`endif

    for (int i = 0; i < 5; i++) step();
    check("load_queue_empty", q_load_cyc.size(), 0);
    check("update_queue_empty", q_upd_cyc.size(), 0);
    check("digest_queue_empty", q_dig_cyc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
